iq_scheduler: RTL and testbench

Entry allocator and oldest-first select scheduler for the issue queue. Tracks which IQ entries are occupied and supplies up to two free entry numbers per cycle to dispatch. Keeps an age matrix over entries and, each cycle, grants the oldest ready entry on each execution port. Frees granted or killed entries at the next clock edge.

---
 rtl/iq_scheduler_pkg.sv | 15 +
 rtl/iq_scheduler_if.sv | 21 ++
 rtl/iq_oldest_select.sv | 22 ++
 rtl/iq_scheduler.sv | 78 +++++++
 tb/tb_iq_scheduler.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/iq_scheduler_pkg.sv
// iq_scheduler_pkg: issue-queue scheduler sizes, types and a population-count helper
package iq_scheduler_pkg;
  localparam int IQ_ENT_NUM = 16;
  localparam int IQ_ENT_SEL = 4;
  localparam int PORT_NUM = 2;
  localparam int PORT_SEL = 1;
  typedef logic [IQ_ENT_NUM-1:0] ent_vec_t;
  typedef logic [IQ_ENT_SEL-1:0] ent_idx_t;
  typedef logic [PORT_SEL-1:0] port_t;
  typedef logic [IQ_ENT_SEL:0] cnt_t;
  function automatic cnt_t popcnt(input ent_vec_t v);
    popcnt = '0;
    for (int i = 0; i < IQ_ENT_NUM; i++) popcnt += cnt_t'(v[i]);
  endfunction
endpackage

// File: rtl/iq_scheduler_if.sv
// iq_scheduler_if: dispatch/alloc, wakeup/kill/flush and grant signals; master drives dispatch side, slave is the scheduler
interface iq_scheduler_if;
  import iq_scheduler_pkg::*;
  logic disp_valid_1, disp_valid_2;
  port_t disp_port_1, disp_port_2;
  ent_idx_t alloc_idx_1, alloc_idx_2;
  logic allocatable;
  cnt_t free_count;
  ent_vec_t ready_vec, kill_vec;
  logic flush;
  logic [PORT_NUM-1:0] grant_valid;
  logic [PORT_NUM*IQ_ENT_SEL-1:0] grant_idx;
  modport master(
    output disp_valid_1, disp_valid_2, disp_port_1, disp_port_2, ready_vec, kill_vec, flush,
    input alloc_idx_1, alloc_idx_2, allocatable, free_count, grant_valid, grant_idx
  );
  modport slave(
    input disp_valid_1, disp_valid_2, disp_port_1, disp_port_2, ready_vec, kill_vec, flush,
    output alloc_idx_1, alloc_idx_2, allocatable, free_count, grant_valid, grant_idx
  );
endinterface

// File: rtl/iq_oldest_select.sv
// iq_oldest_select: req vector + age matrix (older[i][j]=i older than j) -> grant_valid/grant_idx of oldest requester
module iq_oldest_select
  import iq_scheduler_pkg::*;
(
  input  ent_vec_t                  req,
  input  ent_vec_t [IQ_ENT_NUM-1:0] older,
  output logic                      grant_valid,
  output ent_idx_t                  grant_idx
);
  ent_vec_t win;
  always_comb begin
    win = req;
    for (int i = 0; i < IQ_ENT_NUM; i++)
      for (int j = 0; j < IQ_ENT_NUM; j++)
        if (j != i && req[j] && older[j][i]) win[i] = 1'b0;
  end
  always_comb begin
    grant_valid = |win;
    grant_idx = '0;
    for (int i = 0; i < IQ_ENT_NUM; i++) if (win[i]) grant_idx = ent_idx_t'(i);
  end
endmodule

// File: rtl/iq_scheduler.sv
// iq_scheduler: IQ entry allocator (two lowest free indices) and oldest-first per-port select; ports clk, reset, s (slave)
module iq_scheduler
  import iq_scheduler_pkg::*;
(
  input logic          clk,
  input logic          reset,
  iq_scheduler_if.slave s
);
  ent_vec_t occ_q, occ_d, free_lo, free_hi, gmask;
  port_t [IQ_ENT_NUM-1:0] port_q, port_d;
  ent_vec_t [IQ_ENT_NUM-1:0] older_q, older_d;
  ent_vec_t [PORT_NUM-1:0] req;
  logic [PORT_NUM-1:0] gv;
  logic [PORT_NUM*IQ_ENT_SEL-1:0] gidx;
  ent_idx_t idx1, idx2, slot2_idx;
  cnt_t fc;
  logic alc, v1, v2;
  always_comb begin
    free_lo = ~occ_q;
    idx1 = '0;
    for (int i = IQ_ENT_NUM-1; i >= 0; i--) if (free_lo[i]) idx1 = ent_idx_t'(i);
    free_hi = free_lo & ~(ent_vec_t'(1) << idx1);
    idx2 = '0;
    for (int i = IQ_ENT_NUM-1; i >= 0; i--) if (free_hi[i]) idx2 = ent_idx_t'(i);
  end
  assign fc = popcnt(free_lo);
  assign alc = fc > cnt_t'(1);
  assign v1 = alc & ~s.flush & s.disp_valid_1;
  assign v2 = alc & ~s.flush & s.disp_valid_2;
  assign slot2_idx = s.disp_valid_1 ? idx2 : idx1;
  assign s.alloc_idx_1 = idx1;
  assign s.alloc_idx_2 = idx2;
  assign s.free_count = fc;
  assign s.allocatable = alc;
  assign s.grant_valid = gv;
  assign s.grant_idx = gidx;
  always_comb begin
    req = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int i = 0; i < IQ_ENT_NUM; i++)
        req[p][i] = occ_q[i] & s.ready_vec[i] & ~s.kill_vec[i] & (port_q[i] == port_t'(p));
  end
  for (genvar p = 0; p < PORT_NUM; p++) begin : g_sel
    iq_oldest_select u_sel (
      .req(req[p]),
      .older(older_q),
      .grant_valid(gv[p]),
      .grant_idx(gidx[p*IQ_ENT_SEL +: IQ_ENT_SEL])
    );
  end
  always_comb begin
    gmask = '0;
    for (int p = 0; p < PORT_NUM; p++) if (gv[p]) gmask[gidx[p*IQ_ENT_SEL +: IQ_ENT_SEL]] = 1'b1;
  end
  // Slot 2 is applied after slot 1, which leaves slot 1 older than slot 2.
  always_comb begin
    occ_d = s.flush ? '0 : occ_q & ~s.kill_vec & ~gmask;
    port_d = port_q;
    older_d = older_q;
    if (v1) begin
      occ_d[idx1] = 1'b1;
      port_d[idx1] = s.disp_port_1;
      older_d[idx1] = '0;
      for (int j = 0; j < IQ_ENT_NUM; j++) older_d[j][idx1] = 1'b1;
    end
    if (v2) begin
      occ_d[slot2_idx] = 1'b1;
      port_d[slot2_idx] = s.disp_port_2;
      older_d[slot2_idx] = '0;
      for (int j = 0; j < IQ_ENT_NUM; j++) older_d[j][slot2_idx] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    occ_q <= reset ? '0 : occ_d;
    port_q <= port_d;
    older_q <= older_d;
  end
endmodule

// File: tb/tb_iq_scheduler.sv
// tb_iq_scheduler: directed table plus random stimulus against a sequence-number reference model
module tb_iq_scheduler;
  typedef struct {
    bit rst, fl, d1, d2, p1, p2;
    logic [15:0] rdy, kill;
    int a1, a2;
    bit alc;
    int fc;
    bit [1:0] gv;
    int g0, g1;
    bit tab;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  iq_scheduler_if ifc();
  iq_scheduler dut(.clk(clk), .reset(reset), .s(ifc.slave));
  always #5 clk = ~clk;
  int vectors = 0, errs = 0;
  bit m_occ[16];
  int m_port[16], m_seq[16];
  int seq_ctr = 0;
  vec_t tbl[$];
  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic m_out(input logic [15:0] rdy, input logic [15:0] kill, output int a1, output int a2,
                       output bit alc, output int fc, output bit [1:0] gv, output int g[2]);
    a1 = -1; a2 = -1; fc = 0;
    for (int i = 0; i < 16; i++) if (!m_occ[i]) begin
      fc++;
      if (a1 < 0) a1 = i; else if (a2 < 0) a2 = i;
    end
    alc = fc >= 2;
    for (int p = 0; p < 2; p++) begin
      g[p] = -1;
      for (int i = 0; i < 16; i++)
        if (m_occ[i] && rdy[i] && !kill[i] && m_port[i] == p && (g[p] < 0 || m_seq[i] < m_seq[g[p]])) g[p] = i;
      gv[p] = g[p] >= 0;
    end
  endtask
  task automatic m_step(input vec_t v);
    int a1, a2, fc, g[2];
    bit alc;
    bit [1:0] gv;
    m_out(v.rdy, v.kill, a1, a2, alc, fc, gv, g);
    if (v.rst || v.fl) begin
      for (int i = 0; i < 16; i++) m_occ[i] = 0;
    end else begin
      for (int i = 0; i < 16; i++) if (v.kill[i]) m_occ[i] = 0;
      for (int p = 0; p < 2; p++) if (gv[p]) m_occ[g[p]] = 0;
      if (alc && v.d1) begin m_occ[a1] = 1; m_port[a1] = int'(v.p1); m_seq[a1] = seq_ctr++; end
      if (alc && v.d2) begin
        int k;
        k = v.d1 ? a2 : a1;
        m_occ[k] = 1; m_port[k] = int'(v.p2); m_seq[k] = seq_ctr++;
      end
    end
  endtask
  task automatic apply(input vec_t v, input bit mchk);
    int a1, a2, fc, g[2];
    bit alc;
    bit [1:0] gv;
    @(negedge clk);
    reset = v.rst; ifc.flush = v.fl;
    ifc.disp_valid_1 = v.d1; ifc.disp_valid_2 = v.d2;
    ifc.disp_port_1 = v.p1; ifc.disp_port_2 = v.p2;
    ifc.ready_vec = v.rdy; ifc.kill_vec = v.kill;
    #1;
    if (mchk) begin
      m_out(v.rdy, v.kill, a1, a2, alc, fc, gv, g);
      chk("model allocatable", int'(ifc.allocatable), int'(alc));
      chk("model free_count", int'(ifc.free_count), fc);
      if (alc) begin
        chk("model alloc_idx_1", int'(ifc.alloc_idx_1), a1);
        chk("model alloc_idx_2", int'(ifc.alloc_idx_2), a2);
      end
      chk("model grant_valid", int'(ifc.grant_valid), int'(gv));
      for (int p = 0; p < 2; p++) if (gv[p]) chk("model grant_idx", int'(ifc.grant_idx[p*4 +: 4]), g[p]);
    end
    if (v.tab) begin
      chk("tab allocatable", int'(ifc.allocatable), int'(v.alc));
      chk("tab free_count", int'(ifc.free_count), v.fc);
      if (v.alc) begin
        chk("tab alloc_idx_1", int'(ifc.alloc_idx_1), v.a1);
        chk("tab alloc_idx_2", int'(ifc.alloc_idx_2), v.a2);
      end
      chk("tab grant_valid", int'(ifc.grant_valid), int'(v.gv));
      if (v.gv[0]) chk("tab grant_idx p0", int'(ifc.grant_idx[3:0]), v.g0);
      if (v.gv[1]) chk("tab grant_idx p1", int'(ifc.grant_idx[7:4]), v.g1);
    end
    @(posedge clk);
    m_step(v);
  endtask
  function automatic vec_t mk(bit rst, bit fl, bit d1, bit d2, bit p1, bit p2, logic [15:0] rdy, logic [15:0] kill,
                              int a1, int a2, bit alc, int fc, bit [1:0] gv, int g0, int g1);
    vec_t v;
    v.rst = rst; v.fl = fl; v.d1 = d1; v.d2 = d2; v.p1 = p1; v.p2 = p2; v.rdy = rdy; v.kill = kill;
    v.a1 = a1; v.a2 = a2; v.alc = alc; v.fc = fc; v.gv = gv; v.g0 = g0; v.g1 = g1; v.tab = 1;
    return v;
  endfunction
  function automatic vec_t mkin(bit rst, bit fl, bit d1, bit d2, bit p1, bit p2, logic [15:0] rdy, logic [15:0] kill);
    vec_t v;
    v = mk(rst, fl, d1, d2, p1, p2, rdy, kill, 0, 0, 0, 0, 2'b00, 0, 0);
    v.tab = 0;
    return v;
  endfunction
  initial begin
    apply(mkin(1, 0, 0, 0, 0, 0, 16'h0, 16'h0), 0);
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 2, 3, 1, 14, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, 4, 5, 1, 12, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 4, 1, 13, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0009, 16'h0000, 4, 5, 1, 12, 2'b01, 3, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 16'h0000, 16'h0000, 3, 4, 1, 13, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0018, 16'h0000, 5, 6, 1, 11, 2'b11, 3, 4));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h0001, 16'h0007, 3, 4, 1, 13, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 16'h0018, 16'h0000, 0, 1, 1, 14, 2'b01, 3, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 16'h0011, 16'h0000, 1, 2, 1, 14, 2'b11, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16, 2'b00, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1);
    for (int i = 0; i < 7; i++) apply(mkin(0, 0, 1, 1, 0, 0, 16'h0, 16'h0), 1);
    apply(mkin(0, 0, 1, 0, 0, 0, 16'h0, 16'h0), 1);
    tbl.delete();
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0020, 16'h0000, 0, 0, 0, 1, 2'b01, 5, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 5, 15, 1, 2, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 2, 3, 1, 14, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16, 2'b00, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1);
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      v = mkin($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 16'($urandom & $urandom),
               ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom & $urandom) : 16'h0);
      apply(v, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
